// File: rtl/bus_parameters.sv
// bus_parameters: shared constants, FSM state type and word-field helper for
// the bus round-robin arbiter. The optional broadcast delivery is enabled by
// defining BUS_ARB_BCAST_EN when building bus_rr_arbiter.
package bus_parameters;

    localparam int unsigned bits     = 32;
    localparam int unsigned drvrs    = 4;
    localparam int unsigned buses    = 2;
    localparam int unsigned MAX_BITS = 256;

    localparam logic [7:0] BROADCAST_ID = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        DELIVER = 2'd2
    } arb_state_e;

    // Destination ID is the top byte of a word. Callers left-align their word
    // into MAX_BITS so one helper serves every configured word width.
    function automatic logic [7:0] dst_of(input logic [MAX_BITS-1:0] aligned_word);
        return aligned_word[MAX_BITS-1 -: 8];
    endfunction

endpackage

// File: rtl/bus_rr_picker.sv
// bus_rr_picker: combinational round-robin search over the request vector,
// starting at ptr_i and wrapping at DRVRS-1 back to 0.
module bus_rr_picker #(
    parameter int unsigned DRVRS = 4,
    parameter int unsigned IDX_W = $clog2(DRVRS)
) (
    input  logic [DRVRS-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] gnt_o,
    output logic             any_o
);

    // First requester found walking forward from the pointer wins.
    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < int'(DRVRS); i++) begin
            int idx;
            idx = int'(ptr_i) + i;
            if (idx >= int'(DRVRS)) begin
                idx = idx - int'(DRVRS);
            end else begin
                idx = idx;
            end
            if (!any_o && req_i[idx]) begin
                any_o = 1'b1;
                gnt_o = IDX_W'(idx);
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin bus controller for one bus lane. Grants one
// driver FIFO at a time, pops its head word and delivers it to the encoded
// destination. Broadcast delivery is present only when BUS_ARB_BCAST_EN is
// defined; otherwise a broadcast ID is dropped like any invalid ID.
module bus_rr_arbiter
    import bus_parameters::*;
#(
    parameter int unsigned BITS      = bits,
    parameter int unsigned DRVRS     = drvrs,
    parameter logic [7:0]  BROADCAST = BROADCAST_ID
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DRVRS-1:0]            pndng,
    input  logic [DRVRS-1:0][BITS-1:0]  D_pop,
    output logic [DRVRS-1:0]            pop,
    output logic [DRVRS-1:0]            push,
    output logic [DRVRS-1:0][BITS-1:0]  D_push,
    output logic                        busy,
    output logic                        drop
);

    localparam int unsigned      IDX_W = $clog2(DRVRS);
    localparam logic [DRVRS-1:0] ONE_HOT0 = DRVRS'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DRVRS - 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [BITS-1:0]    word_q, word_d;
    logic [DRVRS-1:0]   pop_q, pop_d;
    logic [DRVRS-1:0]   push_q, push_d;
    logic               drop_q, drop_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   pick_s;
    logic               any_s;
    logic [BITS-1:0]    head_s;
    logic [7:0]         dst_s;
    logic               unicast_ok_s;

    bus_rr_picker #(
        .DRVRS (DRVRS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i (pndng),
        .ptr_i (ptr_q),
        .gnt_o (pick_s),
        .any_o (any_s)
    );

    // The granted head word is decoded while it is being popped so the
    // delivery strobes can be registered at the end of GRANT.
    assign head_s       = D_pop[gnt_q];
    assign dst_s        = dst_of(MAX_BITS'(head_s) << (MAX_BITS - BITS));
    assign unicast_ok_s = ({24'd0, dst_s} < DRVRS) && (dst_s != 8'(gnt_q));

    // State and datapath registers; reset loses any in-flight word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            word_q  <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            drop_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            drop_q  <= drop_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: pending requests are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = any_s ? GRANT : IDLE;
            GRANT:   state_d = DELIVER;
            DELIVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        gnt_d  = gnt_q;
        ptr_d  = ptr_q;
        word_d = word_q;
        pop_d  = '0;
        push_d = '0;
        drop_d = 1'b0;
        busy_d = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    gnt_d = pick_s;
                    pop_d = ONE_HOT0 << pick_s;
                end else begin
                    gnt_d = gnt_q;
                end
            end
            GRANT: begin
                word_d = head_s;
                ptr_d  = (gnt_q == LAST_IDX) ? '0 : gnt_q + IDX_W'(1);
                if (unicast_ok_s) begin
                    push_d = ONE_HOT0 << dst_s;
`ifdef BUS_ARB_BCAST_EN
                end else if (dst_s == BROADCAST) begin
                    push_d = ~(ONE_HOT0 << gnt_q);
`endif
                end else begin
                    drop_d = 1'b1;
                end
            end
            DELIVER: begin
                word_d = word_q;
            end
            default: begin
                word_d = word_q;
            end
        endcase
    end

    // Fan the single delivered-word register out to every lane.
    always_comb begin
        for (int i = 0; i < int'(DRVRS); i++) begin
            D_push[i] = word_q;
        end
    end

    assign pop  = pop_q;
    assign push = push_q;
    assign drop = drop_q;
    assign busy = busy_q;

endmodule
